// File: rtl/stage_execute.sv
// rtl/stage_execute.sv - execute stage: operand forwarding, branch resolve, EX/MEM register
package stage_execute_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_mode_t;
endpackage

module stage_execute
  import stage_execute_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [31:0] id_pc_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic        id_op1_pc_i,
  input  logic        id_op2_imm_i,
  input  alu_mode_t   id_alu_mode_i,
  input  logic [3:0]  id_branch_i,
  input  logic        id_load_i,
  input  logic        id_store_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_wb_en_i,
  output alu_mode_t   alu_mode_o,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  input  logic [31:0] alu_result_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_result_o,
  output logic [31:0] ex_store_data_o,
  output logic [4:0]  ex_rd_o,
  output logic        ex_wb_en_o,
  output logic        ex_load_o,
  output logic        ex_store_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  input  logic        flush_i
);

  localparam logic [3:0] BR_EQ   = 4'd1;
  localparam logic [3:0] BR_NE   = 4'd2;
  localparam logic [3:0] BR_LT   = 4'd3;
  localparam logic [3:0] BR_GE   = 4'd4;
  localparam logic [3:0] BR_LTU  = 4'd5;
  localparam logic [3:0] BR_GEU  = 4'd6;
  localparam logic [3:0] BR_JAL  = 4'd7;
  localparam logic [3:0] BR_JALR = 4'd8;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [31:0] ex_result_q, ex_result_d;
  logic [31:0] ex_store_data_q, ex_store_data_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_wb_en_q, ex_wb_en_d;
  logic        ex_load_q, ex_load_d;
  logic        ex_store_q, ex_store_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] fwd_rs1, fwd_rs2, target;
  logic        stall, adv, ready, accept, taken, is_jump;

  // A load result is not known until MEM, so EX/MEM only forwards non-load results.
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf,
                                      input logic ex_hit_ok, input logic [4:0] ex_rd,
                                      input logic [31:0] ex_res, input logic wb_v,
                                      input logic [4:0] wb_rd, input logic [31:0] wb_d);
    if (rs == 5'd0)                    return 32'd0;
    else if (ex_hit_ok && ex_rd == rs) return ex_res;
    else if (wb_v && wb_rd == rs)      return wb_d;
    else                               return rf;
  endfunction

  always_comb begin
    fwd_rs1 = fwd(id_rs1_i, id_rs1_data_i, ex_valid_q & ex_wb_en_q & ~ex_load_q, ex_rd_q,
                  ex_result_q, wb_valid_i, wb_rd_i, wb_data_i);
    fwd_rs2 = fwd(id_rs2_i, id_rs2_data_i, ex_valid_q & ex_wb_en_q & ~ex_load_q, ex_rd_q,
                  ex_result_q, wb_valid_i, wb_rd_i, wb_data_i);

    stall = ex_valid_q && ex_load_q && (ex_rd_q != 5'd0) &&
            ((!id_op1_pc_i && ex_rd_q == id_rs1_i) ||
             ((!id_op2_imm_i || id_store_i) && ex_rd_q == id_rs2_i));
    adv    = !ex_valid_q || ex_ready_i;
    ready  = (adv && !stall) || redirect_q || flush_i;
    // The slot right after a redirect holds a wrong-path instruction: drain it.
    accept = id_valid_i && ready && !redirect_q && !flush_i;

    is_jump = (id_branch_i == BR_JAL) || (id_branch_i == BR_JALR);
    case (id_branch_i)
      BR_EQ:   taken = (fwd_rs1 == fwd_rs2);
      BR_NE:   taken = (fwd_rs1 != fwd_rs2);
      BR_LT:   taken = ($signed(fwd_rs1) <  $signed(fwd_rs2));
      BR_GE:   taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      BR_LTU:  taken = (fwd_rs1 <  fwd_rs2);
      BR_GEU:  taken = (fwd_rs1 >= fwd_rs2);
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (id_branch_i == BR_JALR) target = (fwd_rs1 + id_imm_i) & ~32'd1;
    else                        target = id_pc_i + id_imm_i;

    ex_valid_d      = ex_valid_q;
    ex_pc_d         = ex_pc_q;
    ex_result_d     = ex_result_q;
    ex_store_data_d = ex_store_data_q;
    ex_rd_d         = ex_rd_q;
    ex_wb_en_d      = ex_wb_en_q;
    ex_load_d       = ex_load_q;
    ex_store_d      = ex_store_q;
    redirect_d      = accept && taken;
    redirect_pc_d   = (accept && taken) ? target : redirect_pc_q;

    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d      = 1'b1;
      ex_pc_d         = id_pc_i;
      ex_result_d     = is_jump ? id_pc_i + 32'd4 : alu_result_i;
      ex_store_data_d = fwd_rs2;
      ex_rd_d         = id_rd_i;
      ex_wb_en_d      = id_wb_en_i;
      ex_load_d       = id_load_i;
      ex_store_d      = id_store_i;
    end else if (adv) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ex_valid_q      <= 1'b0;
      ex_pc_q         <= RESET_PC;
      ex_result_q     <= 32'd0;
      ex_store_data_q <= 32'd0;
      ex_rd_q         <= 5'd0;
      ex_wb_en_q      <= 1'b0;
      ex_load_q       <= 1'b0;
      ex_store_q      <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_pc_q   <= 32'd0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_pc_q         <= ex_pc_d;
      ex_result_q     <= ex_result_d;
      ex_store_data_q <= ex_store_data_d;
      ex_rd_q         <= ex_rd_d;
      ex_wb_en_q      <= ex_wb_en_d;
      ex_load_q       <= ex_load_d;
      ex_store_q      <= ex_store_d;
      redirect_q      <= redirect_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  assign id_ready_o      = ready;
  assign alu_mode_o      = id_alu_mode_i;
  assign alu_op1_o       = id_op1_pc_i ? id_pc_i : fwd_rs1;
  assign alu_op2_o       = id_op2_imm_i ? id_imm_i : fwd_rs2;
  assign ex_valid_o      = ex_valid_q;
  assign ex_pc_o         = ex_pc_q;
  assign ex_result_o     = ex_result_q;
  assign ex_store_data_o = ex_store_data_q;
  assign ex_rd_o         = ex_rd_q;
  assign ex_wb_en_o      = ex_wb_en_q;
  assign ex_load_o       = ex_load_q;
  assign ex_store_o      = ex_store_q;
  assign redirect_o      = redirect_q;
  assign redirect_pc_o   = redirect_pc_q;

endmodule

// File: tb/tb_stage_execute.sv
// tb/tb_stage_execute.sv - directed vector bench for stage_execute
module tb_stage_execute;
  import stage_execute_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_op1_pc, id_op2_imm, id_load, id_store, id_wb_en;
  alu_mode_t   id_alu_mode, alu_mode;
  logic [3:0]  id_branch;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_wb_en, ex_load, ex_store, redirect;
  logic [31:0] redirect_pc;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural ALU standing in for the async ALU downstream.
  always_comb begin
    case (alu_mode)
      ALU_SUB: alu_result = alu_op1 - alu_op2;
      ALU_AND: alu_result = alu_op1 & alu_op2;
      ALU_OR:  alu_result = alu_op1 | alu_op2;
      ALU_XOR: alu_result = alu_op1 ^ alu_op2;
      default: alu_result = alu_op1 + alu_op2;
    endcase
  end

  stage_execute #(.RESET_PC(RPC)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .id_valid_i(id_valid), .id_ready_o(id_ready), .id_pc_i(id_pc),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
    .id_op1_pc_i(id_op1_pc), .id_op2_imm_i(id_op2_imm), .id_alu_mode_i(id_alu_mode),
    .id_branch_i(id_branch), .id_load_i(id_load), .id_store_i(id_store),
    .id_rd_i(id_rd), .id_wb_en_i(id_wb_en),
    .alu_mode_o(alu_mode), .alu_op1_o(alu_op1), .alu_op2_o(alu_op2), .alu_result_i(alu_result),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_pc_o(ex_pc), .ex_result_o(ex_result),
    .ex_store_data_o(ex_store_data), .ex_rd_o(ex_rd), .ex_wb_en_o(ex_wb_en),
    .ex_load_o(ex_load), .ex_store_o(ex_store),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc), .flush_i(flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_op1_pc = 0; id_op2_imm = 0; id_alu_mode = ALU_ADD; id_branch = 0;
    id_load = 0; id_store = 0; id_rd = 0; id_wb_en = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                       input logic op2_imm, input alu_mode_t mode, input logic [4:0] rd,
                       input logic wb_en, input logic ld);
    idle();
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_imm = imm; id_op2_imm = op2_imm; id_alu_mode = mode; id_rd = rd; id_wb_en = wb_en;
    id_load = ld;
  endtask

  typedef struct {
    logic [3:0]  br;
    logic [31:0] d1, d2, imm, pc;
    logic        op1_pc, op2_imm;
    alu_mode_t   mode;
    logic [31:0] exp_res;
    logic        exp_redir;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{4'd0, 32'd5, 32'd7, 32'd0, 32'h0, 1'b0, 1'b0, ALU_ADD, 32'd12, 1'b0, 32'h0};
    vecs[1]  = '{4'd0, 32'd20, 32'd0, 32'd3, 32'h10, 1'b0, 1'b1, ALU_SUB, 32'd17, 1'b0, 32'h0};
    vecs[2]  = '{4'd0, 32'd0, 32'd0, 32'h10, 32'h400, 1'b1, 1'b1, ALU_ADD, 32'h410, 1'b0, 32'h0};
    vecs[3]  = '{4'd1, 32'd4, 32'd4, 32'h20, 32'h100, 1'b0, 1'b0, ALU_ADD, 32'd8, 1'b1, 32'h120};
    vecs[4]  = '{4'd2, 32'd4, 32'd4, 32'h20, 32'h100, 1'b0, 1'b0, ALU_ADD, 32'd8, 1'b0, 32'h0};
    vecs[5]  = '{4'd3, 32'hffff_ffff, 32'd1, 32'h8, 32'h300, 1'b0, 1'b0, ALU_ADD, 32'd0, 1'b1, 32'h308};
    vecs[6]  = '{4'd5, 32'hffff_ffff, 32'd1, 32'h8, 32'h300, 1'b0, 1'b0, ALU_ADD, 32'd0, 1'b0, 32'h0};
    vecs[7]  = '{4'd4, 32'hffff_ffff, 32'd1, 32'h8, 32'h300, 1'b0, 1'b0, ALU_ADD, 32'd0, 1'b0, 32'h0};
    vecs[8]  = '{4'd6, 32'hffff_ffff, 32'd1, 32'hffff_fff8, 32'h300, 1'b0, 1'b0, ALU_ADD, 32'd0, 1'b1, 32'h2f8};
    vecs[9]  = '{4'd7, 32'd0, 32'd0, 32'h40, 32'h500, 1'b0, 1'b0, ALU_ADD, 32'h504, 1'b1, 32'h540};
    vecs[10] = '{4'd8, 32'h1001, 32'd0, 32'h4, 32'h200, 1'b0, 1'b1, ALU_ADD, 32'h204, 1'b1, 32'h1004};
    vecs[11] = '{4'd9, 32'd3, 32'd3, 32'h20, 32'h600, 1'b0, 1'b0, ALU_ADD, 32'd6, 1'b0, 32'h0};
    vecs[12] = '{4'd7, 32'd0, 32'd0, 32'h8, 32'hffff_fffc, 1'b0, 1'b0, ALU_ADD, 32'h0, 1'b1, 32'h4};

    idle();
    ex_ready = 1;
    reset_n  = 0;
    tick(); tick();
    check("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst ex_pc", ex_pc, RPC);
    check("rst ex_result", ex_result, 32'd0);
    check("rst store_data", ex_store_data, 32'd0);
    check("rst ctrl", {24'd0, ex_rd, ex_wb_en, ex_load, ex_store}, 32'd0);
    check("rst redirect", {31'd0, redirect}, 32'd0);
    check("rst redirect_pc", redirect_pc, 32'd0);
    reset_n = 1;
    tick();

    for (int i = 0; i < 13; i++) begin
      offer(vecs[i].pc, 5'd10, vecs[i].d1, 5'd11, vecs[i].d2, vecs[i].imm, vecs[i].op2_imm,
            vecs[i].mode, 5'd9, 1'b0, 1'b0);
      id_op1_pc = vecs[i].op1_pc;
      id_branch = vecs[i].br;
      #1 check($sformatf("v%0d id_ready", i), {31'd0, id_ready}, 32'd1);
      tick();
      check($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, 32'd1);
      check($sformatf("v%0d ex_pc", i), ex_pc, vecs[i].pc);
      check($sformatf("v%0d ex_result", i), ex_result, vecs[i].exp_res);
      check($sformatf("v%0d redirect", i), {31'd0, redirect}, {31'd0, vecs[i].exp_redir});
      if (vecs[i].exp_redir) check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].exp_tgt);
      idle();
      tick();
      check($sformatf("v%0d redirect drop", i), {31'd0, redirect}, 32'd0);
      check($sformatf("v%0d drained", i), {31'd0, ex_valid}, 32'd0);
    end

    // EX/MEM forward beats WB forward; then WB forward and x0 handling
    offer(32'h0, 5'd2, 32'd5, 5'd3, 32'd7, 32'd0, 1'b0, ALU_ADD, 5'd1, 1'b1, 1'b0);
    tick();
    offer(32'h4, 5'd1, 32'd0, 5'd0, 32'd0, 32'd3, 1'b1, ALU_SUB, 5'd2, 1'b1, 1'b0);
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'd99;
    #1 check("fwd ex op1", alu_op1, 32'd12);
    tick();
    check("fwd sub result", ex_result, 32'd9);
    offer(32'h8, 5'd1, 32'd0, 5'd0, 32'd55, 32'd0, 1'b0, ALU_ADD, 5'd5, 1'b1, 1'b0);
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'd99;
    #1 check("fwd wb op1", alu_op1, 32'd99);
    check("x0 op2", alu_op2, 32'd0);
    tick();
    check("fwd wb result", ex_result, 32'd99);

    // load-use stall
    offer(32'h10, 5'd12, 32'h40, 5'd0, 32'd0, 32'd0, 1'b1, ALU_ADD, 5'd3, 1'b1, 1'b1);
    tick();
    check("load valid", {31'd0, ex_valid}, 32'd1);
    check("load addr", ex_result, 32'h40);
    offer(32'h14, 5'd3, 32'd50, 5'd0, 32'd0, 32'd1, 1'b1, ALU_ADD, 5'd4, 1'b1, 1'b0);
    #1 check("load-use ready", {31'd0, id_ready}, 32'd0);
    check("no load fwd", alu_op1, 32'd50);
    tick();
    check("load left", {31'd0, ex_valid}, 32'd0);
    check("after stall ready", {31'd0, id_ready}, 32'd1);
    tick();
    check("load-use add", ex_result, 32'd51);
    check("load-use rd", {27'd0, ex_rd}, 32'd4);

    // taken branch: the next offered instruction is wrong-path
    offer(32'h100, 5'd4, 32'd6, 5'd4, 32'd6, 32'h20, 1'b0, ALU_ADD, 5'd0, 1'b0, 1'b0);
    id_branch = 4'd1;
    tick();
    check("beq redirect", {31'd0, redirect}, 32'd1);
    check("beq target", redirect_pc, 32'h120);
    offer(32'h104, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, ALU_ADD, 5'd7, 1'b1, 1'b0);
    #1 check("wrong-path ready", {31'd0, id_ready}, 32'd1);
    tick();
    check("wrong-path dropped", {31'd0, ex_valid}, 32'd0);
    check("redirect one cycle", {31'd0, redirect}, 32'd0);

    // backpressure hold then flush
    offer(32'h700, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, ALU_ADD, 5'd6, 1'b1, 1'b0);
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'd1;
    id_rs2 = 5'd20;
    tick();
    ex_ready = 0;
    offer(32'h704, 5'd8, 32'd8, 5'd9, 32'd9, 32'd0, 1'b0, ALU_ADD, 5'd7, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("hold%0d ready", c), {31'd0, id_ready}, 32'd0);
      tick();
      check($sformatf("hold%0d valid", c), {31'd0, ex_valid}, 32'd1);
      check($sformatf("hold%0d result", c), ex_result, 32'd3);
      check($sformatf("hold%0d pc", c), ex_pc, 32'h700);
    end
    flush = 1;
    #1 check("flush ready", {31'd0, id_ready}, 32'd1);
    tick();
    check("flush cleared", {31'd0, ex_valid}, 32'd0);
    flush = 0;
    ex_ready = 1;
    tick();
    ex_ready = 0;
    tick();
    check("restall valid", {31'd0, ex_valid}, 32'd1);

    // asynchronous reset mid-stall
    #3 reset_n = 0;
    #1;
    check("arst valid", {31'd0, ex_valid}, 32'd0);
    check("arst pc", ex_pc, RPC);
    check("arst result", ex_result, 32'd0);
    check("arst ctrl", {24'd0, ex_rd, ex_wb_en, ex_load, ex_store}, 32'd0);
    idle();
    tick();
    reset_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_execute.md
Name: stage_execute

Overview:
- Execute pipeline stage directly upstream of the async ALU, between decode and memory.
- Latches nothing on input; it selects and forwards operands, drives the ALU combinationally, and evaluates branches.
- Registers the ALU result plus control into the EX/MEM register, with valid/ready handshakes on both sides.
- Produces a registered one-cycle redirect for taken branches and jumps.

Parameters:
- RESET_PC, 32'h0000_0000, value of ex_pc_o after reset.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- id_valid_i  in  1  decode offers an instruction.
- id_ready_o  out  1  stage accepts this cycle.
- id_pc_i  in  32  instruction PC.
- id_rs1_i, id_rs2_i  in  5 each  source register indices.
- id_rs1_data_i, id_rs2_data_i  in  32 each  register-file read data.
- id_imm_i  in  32  sign-extended immediate.
- id_op1_pc_i  in  1  op1 = PC instead of rs1.
- id_op2_imm_i  in  1  op2 = imm instead of rs2.
- id_alu_mode_i  in  alu_mode_t  ALU operation.
- id_branch_i  in  4  0 NONE, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU, 7 JAL, 8 JALR; others treated as NONE.
- id_load_i, id_store_i  in  1 each  memory op flags.
- id_rd_i  in  5  destination register.
- id_wb_en_i  in  1  writes rd.
- alu_mode_o  out  alu_mode_t  to ALU.
- alu_op1_o, alu_op2_o  out  32 each  to ALU.
- alu_result_i  in  32  from ALU, same cycle.
- wb_valid_i  in  1  writeback is writing.
- wb_rd_i  in  5  writeback destination.
- wb_data_i  in  32  writeback data.
- ex_valid_o  out  1  EX/MEM holds an instruction.
- ex_ready_i  in  1  memory stage accepts.
- ex_pc_o  out  32  registered PC.
- ex_result_o  out  32  ALU result, or PC+4 for JAL/JALR.
- ex_store_data_o  out  32  forwarded rs2.
- ex_rd_o  out  5  registered destination.
- ex_wb_en_o, ex_load_o, ex_store_o  out  1 each  registered control.
- redirect_o  out  1  one-cycle taken-branch pulse.
- redirect_pc_o  out  32  target PC.
- flush_i  in  1  trap flush.

Behaviour:
- Reset (asynchronous, reset_n_i=0) values:
  - ex_valid_o=0, ex_pc_o=RESET_PC.
  - ex_result_o, ex_store_data_o, redirect_pc_o=0.
  - ex_rd_o=0; ex_wb_en_o, ex_load_o, ex_store_o=0; redirect_o=0.
  - Reset mid-operation discards the held instruction and any pending redirect.
- Forwarding, per source rs:
  - Index 0 always yields 0.
  - Priority 1, EX/MEM: ex_valid_o & ex_wb_en_o & !ex_load_o & ex_rd_o==rs gives ex_result_o.
  - Priority 2, WB: wb_valid_i & wb_rd_i==rs gives wb_data_i.
  - Otherwise register-file data.
- Operand select: op1 = id_op1_pc_i ? id_pc_i : fwd_rs1; op2 = id_op2_imm_i ? id_imm_i : fwd_rs2. alu_mode_o = id_alu_mode_i, passed through combinationally.
- Load-use stall: when ex_valid_o & ex_load_o & ex_rd_o!=0 and ex_rd_o equals an rs actually consumed (rs1 unless op1_pc; rs2 unless op2_imm, or always for stores), drive id_ready_o=0.
- Accept/advance:
  - adv = !ex_valid_o | ex_ready_i.
  - id_ready_o = adv & !stall, or 1 when redirect_o=1 or flush_i=1.
  - Accept on id_valid_i & id_ready_o: EX/MEM loads all fields, ex_valid_o=1.
  - If adv and nothing is accepted, ex_valid_o becomes 0.
  - If !adv, hold all fields stable.
- Branch evaluation compares fwd_rs1 vs fwd_rs2:
  - LT/GE are signed; LTU/GEU are unsigned.
  - Target = id_pc_i + id_imm_i for conditional branches and JAL.
  - Target = (fwd_rs1 + id_imm_i) & ~1 for JALR.
  - JAL/JALR: ex_result_o = id_pc_i+4, arithmetic mod 2^32.
- Redirect:
  - On accepting a taken branch/jump, redirect_o=1 and redirect_pc_o=target on the next cycle, for exactly one cycle.
  - The instruction offered during the redirect_o=1 cycle is wrong-path: consume it (id_ready_o=1) and do not latch it.
- flush_i (synchronous):
  - Clears ex_valid_o and redirect_o next edge.
  - Squashes any acceptance in that cycle; id_ready_o=1.
  - Flush wins over a simultaneous accept, stall, or redirect.
- Simultaneous WB and EX/MEM match on the same rs: EX/MEM wins.
- rd=0 with wb_en=1 is legal and never forwarded.

Test Plan:
- ADD x1 ← 5+7, ex_ready_i=1 → next cycle ex_valid_o=1, ex_result_o=12, ex_rd_o=1.
- Back-to-back: ADD x1=12 then SUB x2 = x1−3 with stale RF x1=0 → SUB result 9 via EX/MEM forward; with wb_rd_i=1, wb_data_i=99 also asserted, still 9.
- Load x3 followed by ADD x4 = x3+1 → id_ready_o=0 for one cycle; ADD accepted after the load leaves EX/MEM; no forward from a load.
- BEQ pc=0x100, imm=0x20, rs1=rs2=4 → redirect_o pulses once with 0x120; the next offered instruction is consumed and never appears at ex_valid_o. BNE with the same operands → no redirect.
- JALR pc=0x200, rs1=0x1001, imm=4 → ex_result_o=0x204, redirect_pc_o=0x1004.
- ex_ready_i=0 for 3 cycles with ex_valid_o=1 → outputs stable, id_ready_o=0; then flush_i=1 → ex_valid_o=0 next cycle. Async reset mid-stall → all outputs at reset values immediately.
